core_msg_rx: RTL and testbench

Per-core receive stage downstream of the GPU scheduler. It sits at the core end of the 16-bit scheduler message bus and decodes the loading strobes that accompany each word. It captures the core-select mask, the r0 mask, the r0 initial data and the instruction-frame words. It hands the r0 data and a buffered instruction stream to the core's execute pipeline, and drives this core's `core_reading` and `core_ready` bits back to the scheduler.

---
 rtl/core_msg_rx.sv | 195 +++++++++++++++++++
 tb/tb_core_msg_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_msg_rx.sv
`timescale 1ns/1ps
// core_msg_rx
// Per-core receive stage at the core end of the scheduler message bus.
// Decodes the loading strobes and captures the core-select mask, the r0
// mask, the r0 initial data and the instruction words.
// Instruction words go into a show-ahead FIFO with a registered head.
// Optional feature macro: CORE_RX_ERR_EN adds a sticky rx_err output that
// flags dropped instruction words and strobe collisions.
module core_msg_rx #(
  parameter int CORE_ID    = 0,
  parameter int MSG_WIDTH  = 16,
  parameter int R0_DEPTH   = 8,
  parameter int IBUF_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [MSG_WIDTH-1:0]          mess_to_core,
  input  logic                          core_mask_loading,
  input  logic                          r0_mask_loading,
  input  logic                          r0_loading,
  input  logic                          instr_loading,
  output logic                          core_reading,
  output logic                          core_ready,
  output logic [R0_DEPTH*MSG_WIDTH-1:0] r0_data,
  output logic                          r0_valid,
  output logic [MSG_WIDTH-1:0]          instr_out,
  output logic                          instr_valid,
  input  logic                          instr_pop,
  input  logic                          exec_done
`ifdef CORE_RX_ERR_EN
  ,
  output logic                          rx_err
`endif
);

  localparam int PTR_W    = $clog2(IBUF_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int R0_PTR_W = (R0_DEPTH > 1) ? $clog2(R0_DEPTH) : 1;

  localparam logic [CNT_W-1:0]    CNT_FULL  = CNT_W'(IBUF_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_SLACK = CNT_W'(IBUF_DEPTH - 2);
  localparam logic [R0_PTR_W-1:0] R0_LAST   = R0_PTR_W'(R0_DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEL   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [R0_PTR_W-1:0] r0_ptr;
  logic                r0_sel;
  logic [MSG_WIDTH-1:0] r0_mem [R0_DEPTH];

  logic [MSG_WIDTH-1:0] fifo_mem [IBUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     rd_ptr_nxt;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_nxt;
  logic [CNT_W-1:0]     count_after_pop;

  logic [3:0] strobes;
  logic       collision;
  logic       sel_bit;
  logic       cm_ok;
  logic       r0m_ok;
  logic       r0l_ok;
  logic       il_ok;
  logic       fifo_full;
  logic       push_req;
  logic       push_ok;
  logic       pop_ok;

  // Strobe decode: any cycle with two or more loading strobes is ignored.
  assign strobes   = {core_mask_loading, r0_mask_loading, r0_loading, instr_loading};
  assign collision = (strobes & (strobes - 4'd1)) != 4'd0;
  assign sel_bit   = mess_to_core[CORE_ID];
  assign cm_ok     = core_mask_loading & ~collision;
  assign r0m_ok    = r0_mask_loading   & ~collision;
  assign r0l_ok    = r0_loading        & ~collision;
  assign il_ok     = instr_loading     & ~collision;

  // FIFO handshake: pops need a visible head; a full FIFO accepts a push only
  // when a pop frees a slot in the same cycle.
  assign pop_ok          = instr_pop & instr_valid;
  assign fifo_full       = (count == CNT_FULL);
  assign push_req        = il_ok && (state == ST_SEL);
  assign push_ok         = push_req && (!fifo_full || pop_ok);
  assign count_after_pop = count - CNT_W'(pop_ok);
  assign count_nxt       = count_after_pop + CNT_W'(push_ok);
  assign rd_ptr_nxt      = rd_ptr + PTR_W'(pop_ok);

  // Next-state selection for the IDLE / SEL / DRAIN sequence.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cm_ok && sel_bit) state_nxt = ST_SEL;
      ST_SEL:   if (exec_done)        state_nxt = ST_DRAIN;
      ST_DRAIN: if (count == '0)      state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  // Control state, r0 bookkeeping and the registered status bits to the scheduler.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state        <= ST_IDLE;
      r0_ptr       <= '0;
      r0_sel       <= 1'b0;
      r0_valid     <= 1'b0;
      core_ready   <= 1'b1;
      core_reading <= 1'b1;
    end else begin
      state        <= state_nxt;
      core_ready   <= (state_nxt == ST_IDLE);
      core_reading <= (state_nxt != ST_SEL) || (count_nxt <= CNT_SLACK);
      case (state)
        ST_IDLE: begin
          if (cm_ok && sel_bit) begin
            r0_ptr   <= '0;
            r0_valid <= 1'b0;
            r0_sel   <= 1'b0;
          end
        end
        ST_SEL: begin
          if (r0m_ok) r0_sel <= sel_bit;
          if (r0l_ok && r0_sel) begin
            r0_ptr <= (r0_ptr == R0_LAST) ? '0 : r0_ptr + R0_PTR_W'(1);
            if (r0_ptr == R0_LAST) r0_valid <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (count == '0) r0_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // r0 word storage; overwrites wrap back to slot 0 after the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < R0_DEPTH; i++) r0_mem[i] <= '0;
    end else if (state == ST_SEL && r0l_ok && r0_sel) begin
      r0_mem[r0_ptr] <= mess_to_core;
    end
  end

  // Flatten r0 words onto the output bus, word i in slice i.
  always_comb begin
    r0_data = '0;
    for (int i = 0; i < R0_DEPTH; i++) r0_data[i*MSG_WIDTH +: MSG_WIDTH] = r0_mem[i];
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage array is not reset; count and pointers alone define which entries are live.
    if (push_ok) fifo_mem[wr_ptr] <= mess_to_core;
  end

  // FIFO pointers, count and registered head. The head loads from the
  // pre-write array, so a word pushed at edge N is visible after edge N+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      instr_valid <= (count_after_pop != '0);
      instr_out   <= fifo_mem[rd_ptr_nxt];
    end
  end

`ifdef CORE_RX_ERR_EN
  logic drop;
  assign drop = push_req && fifo_full && !pop_ok;

  // Sticky error flag for dropped instruction words and strobe collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_err <= 1'b0;
    end else if (drop || collision) begin
      rx_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_core_msg_rx.sv
`timescale 1ns/1ps
// tb_core_msg_rx: randomized and directed stimulus against a queue-based
// reference model of the receive stage (CORE_ID=3, default sizes).
module tb_core_msg_rx;

  localparam int CORE_ID = 3;
  localparam int MW      = 16;
  localparam int RD      = 8;
  localparam int DEPTH   = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [MW-1:0] mess_to_core;
  logic          core_mask_loading, r0_mask_loading, r0_loading, instr_loading;
  logic          core_reading, core_ready;
  logic [RD*MW-1:0] r0_data;
  logic          r0_valid;
  logic [MW-1:0] instr_out;
  logic          instr_valid;
  logic          instr_pop;
  logic          exec_done;
`ifdef CORE_RX_ERR_EN
  logic          rx_err;
`endif

  always #5 clk = ~clk;

  core_msg_rx #(
    .CORE_ID(CORE_ID), .MSG_WIDTH(MW), .R0_DEPTH(RD), .IBUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .mess_to_core(mess_to_core),
    .core_mask_loading(core_mask_loading), .r0_mask_loading(r0_mask_loading),
    .r0_loading(r0_loading), .instr_loading(instr_loading),
    .core_reading(core_reading), .core_ready(core_ready),
    .r0_data(r0_data), .r0_valid(r0_valid),
    .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_pop(instr_pop), .exec_done(exec_done)
`ifdef CORE_RX_ERR_EN
    , .rx_err(rx_err)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (behavioural, in terms of the operating rules).
  typedef enum int {M_IDLE, M_SEL, M_DRAIN} mode_t;
  mode_t         m_mode;
  logic [MW-1:0] m_q[$];
  int            m_r0_idx;
  bit            m_r0_sel, m_r0_valid;
  logic [MW-1:0] m_r0[RD];
  bit            m_valid, m_ready, m_reading, m_err;
  logic [MW-1:0] m_out;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = M_IDLE;
    m_r0_idx = 0; m_r0_sel = 0; m_r0_valid = 0;
    for (int i = 0; i < RD; i++) m_r0[i] = '0;
    m_valid = 0; m_out = '0; m_ready = 1; m_reading = 1; m_err = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit coll, bsel, pop, push, acc;
    int size_before;
    if (reset) begin
      model_reset();
      return;
    end
    coll = $countones({core_mask_loading, r0_mask_loading, r0_loading, instr_loading}) > 1;
    bsel = mess_to_core[CORE_ID];
    size_before = m_q.size();
    pop  = instr_pop && m_valid;
    push = !coll && instr_loading && (m_mode == M_SEL);
    acc  = push && (size_before < DEPTH || pop);
    if (coll || (push && !acc)) m_err = 1;
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(mess_to_core);
    // Words already stored before this edge, minus any consumed, become the visible head.
    m_valid = (size_before - int'(pop)) > 0;
    if (m_valid) m_out = m_q[0];
    case (m_mode)
      M_IDLE: if (!coll && core_mask_loading && bsel) begin
        m_mode = M_SEL; m_r0_idx = 0; m_r0_valid = 0; m_r0_sel = 0;
      end
      M_SEL: begin
        if (!coll && r0_mask_loading) m_r0_sel = bsel;
        if (!coll && r0_loading && m_r0_sel) begin
          m_r0[m_r0_idx] = mess_to_core;
          if (m_r0_idx == RD - 1) m_r0_valid = 1;
          m_r0_idx = (m_r0_idx + 1) % RD;
        end
        if (exec_done) m_mode = M_DRAIN;
      end
      M_DRAIN: if (size_before == 0) begin
        m_mode = M_IDLE; m_r0_valid = 0;
      end
      default: ;
    endcase
    m_ready   = (m_mode == M_IDLE);
    m_reading = (m_mode != M_SEL) || (m_q.size() <= DEPTH - 2);
  endtask

  task automatic compare_all();
    logic [RD*MW-1:0] exp_vec;
    for (int i = 0; i < RD; i++) exp_vec[i*MW +: MW] = m_r0[i];
    check("core_ready",   128'(core_ready),   128'(m_ready));
    check("core_reading", 128'(core_reading), 128'(m_reading));
    check("r0_valid",     128'(r0_valid),     128'(m_r0_valid));
    check("instr_valid",  128'(instr_valid),  128'(m_valid));
    if (m_valid) check("instr_out", 128'(instr_out), 128'(m_out));
    check("r0_data",      128'(r0_data),      128'(exp_vec));
`ifdef CORE_RX_ERR_EN
    check("rx_err",       128'(rx_err),       128'(m_err));
`endif
  endtask

  // One clock cycle: drive inputs, advance model, sample #1 after the edge.
  task automatic cyc(input logic [3:0] stb, input logic [MW-1:0] w,
                     input logic pop, input logic done);
    {core_mask_loading, r0_mask_loading, r0_loading, instr_loading} = stb;
    mess_to_core = w; instr_pop = pop; exec_done = done;
    model_step();
    @(posedge clk); #1;
    compare_all();
  endtask

  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_CM   = 4'b1000;
  localparam logic [3:0] S_R0M  = 4'b0100;
  localparam logic [3:0] S_R0   = 4'b0010;
  localparam logic [3:0] S_IN   = 4'b0001;

  initial begin
    int r, pop_pct;
    logic [3:0] stb;
    logic [MW-1:0] w;
    model_reset();
    reset = 1'b1;
    cyc(S_NONE, '0, 0, 0);
    cyc(S_NONE, '0, 0, 0);
    check("rst_instr_out", 128'(instr_out), 128'(0));
    check("rst_ready",     128'(core_ready), 128'(1));
    reset = 1'b0;

    // Select and r0 load.
    cyc(S_CM, 16'h0008, 0, 0);
    check("ready_after_mask", 128'(core_ready), 128'(0));
    cyc(S_R0M, 16'h0008, 0, 0);
    for (int i = 0; i < RD; i++) cyc(S_R0, 16'h1000 + 16'(i), 0, 0);
    check("r0_valid_after_8", 128'(r0_valid), 128'(1));
    for (int i = 0; i < RD; i++)
      check("r0_word", 128'(r0_data[i*MW +: MW]), 128'(16'h1000 + 16'(i)));
    cyc(S_NONE, '0, 0, 1);
    cyc(S_NONE, '0, 0, 0);
    cyc(S_NONE, '0, 0, 0);
    check("idle_after_empty_drain", 128'(core_ready), 128'(1));

    // Not selected: instruction words must not reach the FIFO.
    cyc(S_CM, 16'hFFF7, 0, 0);
    for (int i = 0; i < 16; i++) cyc(S_IN, 16'h2000 + 16'(i), 0, 0);
    check("unsel_valid", 128'(instr_valid), 128'(0));

    // Backpressure, overflow, push+pop at full, then drain with 3 words.
    cyc(S_CM, 16'h0008, 0, 0);
    for (int i = 0; i < 14; i++) cyc(S_IN, 16'h3000 + 16'(i), 0, 0);
    check("reading_at_14", 128'(core_reading), 128'(1));
    cyc(S_IN, 16'h300E, 0, 0);
    check("reading_at_15", 128'(core_reading), 128'(0));
    cyc(S_IN, 16'h300F, 0, 0);
    cyc(S_IN, 16'h3FFF, 0, 0);
    for (int i = 0; i < 4; i++) cyc(S_IN, 16'h4000 + 16'(i), 1, 0);
    for (int i = 0; i < 13; i++) cyc(S_NONE, '0, 1, 0);
    check("three_left_valid", 128'(instr_valid), 128'(1));
    cyc(S_NONE, '0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(S_NONE, '0, 1, 0);
    cyc(S_NONE, '0, 0, 0);
    check("drain_ready", 128'(core_ready), 128'(1));
    check("drain_r0_valid", 128'(r0_valid), 128'(0));

    // Reset in SEL with 5 words buffered.
    cyc(S_CM, 16'h0008, 0, 0);
    for (int i = 0; i < 5; i++) cyc(S_IN, 16'h5000 + 16'(i), 0, 0);
    reset = 1'b1;
    cyc(S_NONE, '0, 0, 0);
    reset = 1'b0;
    check("rst_sel_valid", 128'(instr_valid), 128'(0));
    check("rst_sel_ready", 128'(core_ready), 128'(1));

    // Randomized traffic, including collisions and occasional resets.
    pop_pct = 30;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) pop_pct = $urandom_range(5, 80);
      r = $urandom_range(0, 99);
      w = 16'($urandom);
      if (r < 35)      stb = S_NONE;
      else if (r < 60) stb = S_IN;
      else if (r < 70) stb = S_R0;
      else if (r < 75) stb = S_R0M;
      else if (r < 82) stb = S_CM;
      else if (r < 86) stb = S_R0 | S_IN;
      else if (r < 88) stb = S_CM | S_R0M | 4'(1 << $urandom_range(0, 3));
      else             stb = S_NONE;
      reset = ($urandom_range(0, 999) == 0);
      cyc(stb, w, $urandom_range(0, 99) < pop_pct, $urandom_range(0, 79) == 0);
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
